// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one registered adder between NUM_REQ requesters.
// Define ADDER_ARBITER_STATS_EN to enable the 16-bit completed-operation counter on ops_o.
module adder_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_v_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          resp_v_o,
  output logic [ID_WIDTH-1:0]           resp_id_o,
  output logic [DATA_WIDTH:0]           resp_sum_o,
  input  logic                          resp_ready_i,
  output logic [DATA_WIDTH-1:0]         adder_a_o,
  output logic [DATA_WIDTH-1:0]         adder_b_o,
  input  logic [DATA_WIDTH:0]           adder_sum_i,
  output logic [15:0]                   ops_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state;
  logic [ID_WIDTH-1:0] last_grant, gnt_id, cand, id_q;
  logic gnt_any;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic [DATA_WIDTH:0] sum_q;
  logic resp_v;
  // scan from highest to lowest offset so the nearest candidate after last_grant wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    cand = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = ID_WIDTH'((int'(last_grant) + i) % NUM_REQ);
      if (req_v_i[cand]) begin
        gnt_any = 1'b1;
        gnt_id = cand;
      end
    end
  end
  assign req_ready_o = (state == IDLE && gnt_any) ? NUM_REQ'(1) << gnt_id : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
      id_q <= '0;
      op_a <= '0;
      op_b <= '0;
      sum_q <= '0;
      resp_v <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          op_a <= req_a_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
          op_b <= req_b_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
          id_q <= gnt_id;
          last_grant <= gnt_id;
          state <= ISSUE;
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          sum_q <= adder_sum_i;
          resp_v <= 1'b1;
          state <= RESP;
        end
        RESP: if (resp_ready_i) begin
          resp_v <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign adder_a_o = op_a;
  assign adder_b_o = op_b;
  assign resp_v_o = resp_v;
  assign resp_id_o = id_q;
  assign resp_sum_o = sum_q;
`ifdef ADDER_ARBITER_STATS_EN
  logic [15:0] ops;
  always_ff @(posedge clk_i) begin
    if (rst_i) ops <= '0;
    else if (resp_v && resp_ready_i) ops <= ops + 16'd1;
  end
  assign ops_o = ops;
`else
  assign ops_o = '0;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed checks of adder_arbiter with a registered adder model.
module tb_adder_arbiter;
  localparam int DW = 6;
  localparam int NR = 4;
  localparam int IW = 2;
`ifdef ADDER_ARBITER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  logic clk_i = 1'b0;
  logic rst_i;
  logic [NR-1:0] req_v, req_ready;
  logic [NR*DW-1:0] req_a, req_b;
  logic resp_v, resp_ready;
  logic [IW-1:0] resp_id;
  logic [DW:0] resp_sum, adder_sum;
  logic [DW-1:0] adder_a, adder_b;
  logic [15:0] ops;
  int errors = 0;
  int checks = 0;
  int exp_ops = 0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) adder_sum <= rst_i ? '0 : {1'b0, adder_a} + {1'b0, adder_b};
  adder_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_v_i(req_v), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready), .resp_v_o(resp_v), .resp_id_o(resp_id), .resp_sum_o(resp_sum),
    .resp_ready_i(resp_ready), .adder_a_o(adder_a), .adder_b_o(adder_b),
    .adder_sum_i(adder_sum), .ops_o(ops)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk_i);
  endtask
  task automatic set_req(input int k, input int a, input int b);
    req_a[k*DW +: DW] = DW'(a);
    req_b[k*DW +: DW] = DW'(b);
  endtask
  // single-requester transaction, entered and left at a negedge in IDLE with resp_ready=1
  task automatic op(input int k, input int a, input int b);
    set_req(k, a, b);
    req_v = NR'(1) << k;
    #1 check("grant", 32'(req_ready), 32'(NR'(1) << k));
    tick();
    req_v = '0;
    check("issue_ready", 32'(req_ready), 0);
    check("adder_a", 32'(adder_a), a);
    check("adder_b", 32'(adder_b), b);
    tick();
    check("capture_v", 32'(resp_v), 0);
    tick();
    check("resp_v", 32'(resp_v), 1);
    check("resp_id", 32'(resp_id), k);
    check("resp_sum", 32'(resp_sum), a + b);
    tick();
    exp_ops += STATS;
    check("resp_done", 32'(resp_v), 0);
    check("ops", 32'(ops), exp_ops);
  endtask
  initial begin
    rst_i = 1'b1;
    req_v = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b1;
    repeat (2) tick();
    check("rst_resp_v", 32'(resp_v), 0);
    check("rst_resp_id", 32'(resp_id), 0);
    check("rst_resp_sum", 32'(resp_sum), 0);
    check("rst_adder_a", 32'(adder_a), 0);
    check("rst_adder_b", 32'(adder_b), 0);
    check("rst_ops", 32'(ops), 0);
    check("rst_ready_idle", 32'(req_ready), 0);
    set_req(0, 5, 7);
    req_v = 4'b0001;
    #1 check("rst_arb_ready", 32'(req_ready), 1);
    tick();
    check("rst_wins_adder_a", 32'(adder_a), 0);
    check("rst_wins_ready", 32'(req_ready), 1);
    rst_i = 1'b0;
    req_v = '0;
    tick();
    op(2, 12, 30);
    op(1, 63, 63);
    set_req(3, 20, 21);
    req_v = 4'b1000;
    #1 check("mid_grant", 32'(req_ready), 8);
    tick();
    req_v = '0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_ops = 0;
    check("mid_resp_v", 32'(resp_v), 0);
    check("mid_adder_a", 32'(adder_a), 0);
    check("mid_resp_sum", 32'(resp_sum), 0);
    check("mid_resp_id", 32'(resp_id), 0);
    check("mid_ops", 32'(ops), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dropped_no_resp", 32'(resp_v), 0);
    end
    for (int k = 0; k < NR; k++) set_req(k, 10 * k + 3, 50 - k);
    req_v = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1 check("rr_grant", 32'(req_ready), 32'(NR'(1) << (g % NR)));
      repeat (3) tick();
      check("rr_resp_id", 32'(resp_id), g % NR);
      check("rr_resp_sum", 32'(resp_sum), 10 * (g % NR) + 3 + 50 - (g % NR));
      tick();
      exp_ops += STATS;
    end
    check("rr_ops", 32'(ops), exp_ops);
    resp_ready = 1'b0;
    #1 check("bp_grant", 32'(req_ready), 2);
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_resp_v", 32'(resp_v), 1);
      check("bp_resp_id", 32'(resp_id), 1);
      check("bp_resp_sum", 32'(resp_sum), 13 + 49);
      check("bp_ready", 32'(req_ready), 0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    exp_ops += STATS;
    #1 check("bp_resume", 32'(req_ready), 4);
    check("bp_resp_done", 32'(resp_v), 0);
    tick();
    req_v = '0;
    repeat (2) tick();
    check("last_resp_id", 32'(resp_id), 2);
    check("last_resp_sum", 32'(resp_sum), 23 + 48);
    tick();
    exp_ops += STATS;
    check("final_ops", 32'(ops), exp_ops);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
